// File: rtl/pec_mac_feeder.sv
// rtl/pec_mac_feeder.sv - PE-controller feeder driving one sparse MAC lane over the PEC<->MAC block protocol
//
// Purpose:
//   Accepts cfg_num_blk compressed blocks per job and issues one start pulse per
//   block whose activation and weight flags overlap. Operands are held stable
//   until the MAC reports finish. The partial sum is passed through the MAC
//   chain, and the final sum is returned on a result handshake.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_start/num_blk/bias        job start pulse, block count and initial psum
//   blk_vld/blk_rdy, blk_*        compressed block input (flags + packed data)
//   PECMAC_*, MACMAC_Mac          held operands, start pulse, psum to MAC
//   MACPEC_Fnh, MACCNV_Mac        MAC finish level and accumulator
//   res_vld/res_rdy/res_mac/err   result handshake
//   busy                          job in progress
module pec_mac_feeder #(
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_DEPTH = 32,
    parameter int ACC_WIDTH   = 23,
    parameter int NUM_BLK_W   = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_start,
    input  logic [NUM_BLK_W-1:0]              cfg_num_blk,
    input  logic [ACC_WIDTH-1:0]              cfg_bias,
    input  logic                              blk_vld,
    output logic                              blk_rdy,
    input  logic [BLOCK_DEPTH-1:0]            blk_flg_act,
    input  logic [DATA_WIDTH*BLOCK_DEPTH-1:0] blk_act,
    input  logic [BLOCK_DEPTH-1:0]            blk_flg_wei,
    input  logic [DATA_WIDTH*BLOCK_DEPTH-1:0] blk_wei,
    output logic                              PECMAC_Sta,
    output logic [BLOCK_DEPTH-1:0]            PECMAC_FlgAct,
    output logic [DATA_WIDTH*BLOCK_DEPTH-1:0] PECMAC_Act,
    output logic [BLOCK_DEPTH-1:0]            PECMAC_FlgWei,
    output logic [DATA_WIDTH*BLOCK_DEPTH-1:0] PECMAC_Wei,
    output logic [ACC_WIDTH-1:0]              MACMAC_Mac,
    input  logic                              MACPEC_Fnh,
    input  logic [ACC_WIDTH-1:0]              MACCNV_Mac,
    output logic                              res_vld,
    input  logic                              res_rdy,
    output logic [ACC_WIDTH-1:0]              res_mac,
    output logic                              res_err,
    output logic                              busy
);

    localparam int PW = DATA_WIDTH * BLOCK_DEPTH;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_HOLD, S_WAIT, S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_BLK_W-1:0]   cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   psum_q, psum_d;
    logic                   err_q, err_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [BLOCK_DEPTH-1:0] flg_act_q, flg_act_d, flg_wei_q, flg_wei_d;
    logic [PW-1:0]          act_q, act_d, wei_q, wei_d;
    logic [ACC_WIDTH-1:0]   mac_q, mac_d;

    logic blk_hs;
    logic blk_live;
    logic last_blk;
    logic timed_out;

    assign blk_hs    = (state_q == S_FETCH) && blk_vld;
    // A block with no position where both operands are nonzero contributes nothing.
    assign blk_live  = |(blk_flg_act & blk_flg_wei);
    assign last_blk  = (cnt_q == NUM_BLK_W'(1));
    // Timer starts at 0 in the first HOLD cycle, so TIMEOUT-1 marks the last allowed cycle.
    assign timed_out = (timer_q == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cfg_start) state_d = (cfg_num_blk != '0) ? S_FETCH : S_DONE;
            S_FETCH: if (blk_vld)   state_d = blk_live ? S_ISSUE : (last_blk ? S_DONE : S_FETCH);
            S_ISSUE: state_d = S_HOLD;
            // MAC still shows the previous Fnh level for three cycles after Sta.
            S_HOLD:  if (timer_q == TW'(2)) state_d = S_WAIT;
            S_WAIT: begin
                if (MACPEC_Fnh)     state_d = last_blk ? S_DONE : S_FETCH;
                else if (timed_out) state_d = S_DONE;
            end
            S_DONE:  if (res_rdy)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        blk_rdy    = (state_q == S_FETCH);
        PECMAC_Sta = (state_q == S_ISSUE);
        res_vld    = (state_q == S_DONE);
        res_mac    = (state_q == S_DONE) ? psum_q : '0;
        res_err    = (state_q == S_DONE) ? err_q : 1'b0;
        busy       = (state_q != S_IDLE);
    end

    // Datapath next-state
    always_comb begin
        cnt_d     = cnt_q;
        psum_d    = psum_q;
        err_d     = err_q;
        timer_d   = timer_q;
        flg_act_d = flg_act_q;
        flg_wei_d = flg_wei_q;
        act_d     = act_q;
        wei_d     = wei_q;
        mac_d     = mac_q;
        if (state_q == S_IDLE && cfg_start) begin
            psum_d = cfg_bias;
            cnt_d  = cfg_num_blk;
            err_d  = 1'b0;
        end
        if (blk_hs) begin
            flg_act_d = blk_flg_act;
            flg_wei_d = blk_flg_wei;
            act_d     = blk_act;
            wei_d     = blk_wei;
            mac_d     = psum_q;
            if (!blk_live) cnt_d = cnt_q - NUM_BLK_W'(1);
        end
        if (state_q == S_ISSUE) timer_d = '0;
        if (state_q == S_HOLD || state_q == S_WAIT) timer_d = timer_q + TW'(1);
        if (state_q == S_WAIT) begin
            if (MACPEC_Fnh) begin
                psum_d = MACCNV_Mac;
                cnt_d  = cnt_q - NUM_BLK_W'(1);
            end else if (timed_out) begin
                err_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            psum_q    <= '0;
            err_q     <= 1'b0;
            timer_q   <= '0;
            flg_act_q <= '0;
            flg_wei_q <= '0;
            act_q     <= '0;
            wei_q     <= '0;
            mac_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            psum_q    <= psum_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            flg_act_q <= flg_act_d;
            flg_wei_q <= flg_wei_d;
            act_q     <= act_d;
            wei_q     <= wei_d;
            mac_q     <= mac_d;
        end
    end

    assign PECMAC_FlgAct = flg_act_q;
    assign PECMAC_FlgWei = flg_wei_q;
    assign PECMAC_Act    = act_q;
    assign PECMAC_Wei    = wei_q;
    assign MACMAC_Mac    = mac_q;

endmodule

// File: tb/tb_pec_mac_feeder.sv
// tb/tb_pec_mac_feeder.sv - scoreboard bench for pec_mac_feeder
module tb_pec_mac_feeder;

    localparam int DW = 8, BD = 32, AW = 23, NW = 8, TO = 255, PW = DW * BD;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_start;
    logic [NW-1:0]  cfg_num_blk;
    logic [AW-1:0]  cfg_bias;
    logic           blk_vld;
    logic           blk_rdy;
    logic [BD-1:0]  blk_flg_act, blk_flg_wei;
    logic [PW-1:0]  blk_act, blk_wei;
    logic           PECMAC_Sta;
    logic [BD-1:0]  PECMAC_FlgAct, PECMAC_FlgWei;
    logic [PW-1:0]  PECMAC_Act, PECMAC_Wei;
    logic [AW-1:0]  MACMAC_Mac;
    logic           MACPEC_Fnh = 1'b1;
    logic [AW-1:0]  MACCNV_Mac = AW'(123);
    logic           res_vld;
    logic           res_rdy;
    logic [AW-1:0]  res_mac;
    logic           res_err;
    logic           busy;

    always #5 clk = ~clk;

    pec_mac_feeder #(.DATA_WIDTH(DW), .BLOCK_DEPTH(BD), .ACC_WIDTH(AW),
                     .NUM_BLK_W(NW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_blk(cfg_num_blk),
        .cfg_bias(cfg_bias), .blk_vld(blk_vld), .blk_rdy(blk_rdy),
        .blk_flg_act(blk_flg_act), .blk_act(blk_act), .blk_flg_wei(blk_flg_wei),
        .blk_wei(blk_wei), .PECMAC_Sta(PECMAC_Sta), .PECMAC_FlgAct(PECMAC_FlgAct),
        .PECMAC_Act(PECMAC_Act), .PECMAC_FlgWei(PECMAC_FlgWei), .PECMAC_Wei(PECMAC_Wei),
        .MACMAC_Mac(MACMAC_Mac), .MACPEC_Fnh(MACPEC_Fnh), .MACCNV_Mac(MACCNV_Mac),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_mac(res_mac), .res_err(res_err),
        .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] mac;
        logic [PW-1:0] act;
    } sta_t;

    sta_t          sta_q[$];
    logic [AW:0]   res_q[$];
    int            cyc = 0;
    int            sta_cnt = 0;
    int            sta_cyc = 0;
    int            res_cyc = 0;
    logic          res_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // MAC lane model: Fnh drops on Sta, returns m_delay cycles later with psum + m_add.
    int            m_delay = 6;
    logic [AW-1:0] m_add = '0;
    bit            m_never = 1'b0;
    int            m_cnt = -1;
    logic [AW-1:0] m_cap;
    logic [PW-1:0] act_cap;

    always @(negedge clk) begin
        if (rst) begin
            m_cnt = -1;
        end else if (PECMAC_Sta) begin
            MACPEC_Fnh = 1'b0;
            m_cnt      = 0;
            m_cap      = MACMAC_Mac;
            act_cap    = PECMAC_Act;
        end else if (m_cnt >= 0) begin
            m_cnt++;
            if (m_cnt == m_delay && !m_never) begin
                check("act_stable", PECMAC_Act, act_cap);
                MACPEC_Fnh = 1'b1;
                MACCNV_Mac = m_cap + m_add;
                m_cnt      = -1;
            end
        end
    end

    // Scoreboard monitor
    sta_t        se;
    logic [AW:0] re;
    always @(negedge clk) begin
        if (!rst) begin
            if (PECMAC_Sta) begin
                sta_cnt++;
                sta_cyc = cyc;
                if (sta_q.size() == 0) begin
                    check("sta_unexpected", 1, 0);
                end else begin
                    se = sta_q.pop_front();
                    check("macmac_mac", MACMAC_Mac, se.mac);
                    check("pecmac_act", PECMAC_Act, se.act);
                end
            end
            if (res_vld && !res_seen) begin
                res_cyc  = cyc;
                res_seen = 1'b1;
            end
            if (!res_vld) res_seen = 1'b0;
            if (res_vld && res_rdy) begin
                if (res_q.size() == 0) begin
                    check("res_unexpected", 1, 0);
                end else begin
                    re = res_q.pop_front();
                    check("res_mac", res_mac, re[AW-1:0]);
                    check("res_err", res_err, re[AW]);
                end
            end
        end
    end

    function automatic logic [PW-1:0] rnd();
        logic [PW-1:0] r;
        for (int i = 0; i < PW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic start_job(input logic [AW-1:0] bias, input int n);
        cfg_bias    = bias;
        cfg_num_blk = n[NW-1:0];
        cfg_start   = 1'b1;
        @(negedge clk);
        cfg_start   = 1'b0;
    endtask

    task automatic send_blk(input logic [BD-1:0] fa, input logic [BD-1:0] fw,
                            input logic [PW-1:0] a, input logic [PW-1:0] w);
        bit ok;
        ok          = 1'b0;
        blk_flg_act = fa;
        blk_flg_wei = fw;
        blk_act     = a;
        blk_wei     = w;
        blk_vld     = 1'b1;
        for (int t = 0; t < 2000 && !ok; t++) begin
            ok = blk_rdy;
            @(negedge clk);
        end
        blk_vld = 1'b0;
        if (!ok) check("blk_rdy_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(tag, busy, 0);
    endtask

    task automatic run_job(input logic [AW-1:0] bias, input int n, input logic [AW-1:0] add,
                           input logic [7:0] skip, input bit err);
        logic [AW-1:0] ps;
        logic [PW-1:0] acts[8];
        logic [PW-1:0] weis[8];
        sta_t          e;
        int            s0, nsta;
        ps    = bias;
        nsta  = 0;
        m_add = add;
        for (int b = 0; b < n; b++) begin
            acts[b] = rnd();
            weis[b] = rnd();
            if (!skip[b]) begin
                e.mac = ps;
                e.act = acts[b];
                sta_q.push_back(e);
                nsta++;
                if (!err) ps = ps + add;
            end
        end
        res_q.push_back({err, ps});
        s0 = sta_cnt;
        start_job(bias, n);
        for (int b = 0; b < n; b++) begin
            if (skip[b]) send_blk(32'h0000FFFF, 32'hFFFF0000, acts[b], weis[b]);
            else         send_blk($urandom | 1, $urandom | 1, acts[b], weis[b]);
        end
        wait_idle("job_idle");
        check("sta_count", sta_cnt - s0, nsta);
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b1; cfg_num_blk = 8'd3; cfg_bias = AW'(9);
        blk_vld = 1'b0; blk_flg_act = '0; blk_flg_wei = '0; blk_act = '0; blk_wei = '0;
        res_rdy = 1'b1;

        // Reset with cfg_start asserted
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_blk_rdy", blk_rdy, 0);
        check("rst_sta", PECMAC_Sta, 0);
        check("rst_res_vld", res_vld, 0);
        check("rst_res_mac", res_mac, 0);
        check("rst_res_err", res_err, 0);
        check("rst_macmac", MACMAC_Mac, 0);
        check("rst_act", PECMAC_Act, 0);
        check("rst_wei", PECMAC_Wei, 0);
        check("rst_flg", {PECMAC_FlgAct, PECMAC_FlgWei}, 0);
        rst = 1'b0; cfg_start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);

        // Single block: bias 5, MAC returns 105
        m_delay = 6;
        run_job(AW'(5), 1, AW'(100), 8'b0, 1'b0);

        // Three blocks chained, negative bias
        m_delay = 9;
        run_job(AW'(-4), 3, AW'(10), 8'b0, 1'b0);

        // Middle block has no overlapping flags, Fnh at first WAIT cycle
        m_delay = 4;
        run_job(AW'(0), 3, AW'(10), 8'b010, 1'b0);

        // Empty job with backpressured result
        res_rdy = 1'b0;
        res_q.push_back({1'b0, AW'(7)});
        start_job(AW'(7), 0);
        check("zero_res_vld", res_vld, 1);
        for (int i = 0; i < 4; i++) begin
            check("zero_hold_vld", res_vld, 1);
            check("zero_hold_mac", res_mac, AW'(7));
            check("zero_blk_rdy", blk_rdy, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 res_rdy = 1'b1;
        wait_idle("zero_idle");

        // MAC never finishes: timeout
        m_never = 1'b1;
        run_job(AW'(9), 1, AW'(0), 8'b0, 1'b1);
        check("timeout_latency", res_cyc - sta_cyc, TO + 1);

        // Reset while waiting on the MAC
        begin
            sta_t e;
            logic [PW-1:0] a;
            a = rnd();
            e.mac = AW'(3);
            e.act = a;
            sta_q.push_back(e);
            start_job(AW'(3), 1);
            send_blk(32'h1, 32'h1, a, rnd());
            repeat (6) @(negedge clk);
            check("wait_busy", busy, 1);
            rst = 1'b1;
            @(negedge clk);
            check("midrst_busy", busy, 0);
            check("midrst_sta", PECMAC_Sta, 0);
            check("midrst_res_vld", res_vld, 0);
            rst = 1'b0;
            @(negedge clk);
        end
        m_never = 1'b0;

        // Recovery job after mid-job reset
        m_delay = 7;
        run_job(AW'(1), 2, AW'(-3), 8'b0, 1'b0);

        check("sta_q_empty", sta_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
